imm_gen_stage: RTL
==================

// Module: imm_gen_stage
// PURPOSE
//  Registered immediate-generation stage between fetch and decode/execute.
//  Accepts one 32-bit instruction per cycle on a valid/ready handshake and extracts the immediate, sign/zero-extended to XLEN.
//  Also classifies the immediate format, flags unknown opcodes, and carries an opaque tag (e.g. PC) alongside.
//  A 2-entry skid buffer gives full throughput under back-pressure with registered in_ready.
// PARAMETERS
//  XLEN   32  immediate/output width; legal values 32 or 64
//  TAG_W  32  width of passthrough tag
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous pipeline flush
//  in_valid   in   1      upstream instruction valid
//  in_ready   out  1      stage can accept this cycle
//  in_inst    in   32     instruction word
//  in_tag     in   TAG_W  tag travelling with instruction
//  out_valid  out  1      output entry valid
//  out_ready  in   1      downstream accepts this cycle
//  out_imm    out  XLEN   extended immediate
//  out_fmt    out  3      0 NONE,1 I,2 S,3 B,4 U,5 J,6 SHAMT,7 ZIMM
//  out_illegal out 1      opcode not recognised
//  out_tag    out  TAG_W  tag of output entry
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, out_imm/out_fmt/out_illegal/out_tag=0, skid empty.
//  - Accept = in_valid & in_ready; push = out_valid & out_ready. Latency 1: an accepted instruction appears on out_* the next cycle.
//  - States: EMPTY (main invalid), BUSY (main valid, skid empty), FULL (both valid). in_ready = !FULL, registered.
//  - EMPTY --accept--> BUSY.
//  - BUSY: accept & !push -> FULL (new entry to skid); accept & push -> BUSY (main reloads); push only -> EMPTY.
//  - FULL: push -> BUSY (skid moves to main); no accept possible.
//  - Order strictly preserved; no entry dropped or duplicated. out_* stable while out_valid & !out_ready.
//  - flush: next cycle EMPTY, in_ready=1. Overrides a simultaneous accept and push; the accepted instruction is discarded.
//  - Reset asserted mid-operation: immediately EMPTY, all outputs at reset values.
//  - Immediate formation (inst = in_inst); all sign extension from inst[31] to XLEN:
//      0000011 LOAD, 1100111 JALR, 0010011 OP-IMM non-shift: I = inst[31:20]
//      0010011 funct3 001/101: SHAMT, zero-extended; inst[24:20] if XLEN=32, inst[25:20] if XLEN=64
//      0011011 OP-IMM-32, XLEN=64 only: funct3 001/101 -> SHAMT inst[24:20]; else I. With XLEN=32: illegal
//      0100011 S = {inst[31:25],inst[11:7]}
//      1100011 B = {inst[31],inst[7],inst[30:25],inst[11:8],0}
//      1101111 J = {inst[31],inst[19:12],inst[20],inst[30:21],0}
//      0110111 LUI, 0010111 AUIPC: U = {inst[31:12],12'b0}, sign-extended
//      0110011 OP, 0111011 OP-32 (XLEN=64), 0001111 FENCE: fmt NONE, imm 0, legal
//      1110011 SYSTEM: see CONFIGURATION
//      any other: fmt NONE, imm 0, out_illegal=1
// CONFIGURATION
//  IMM_GEN_ZIMM_EN defined: SYSTEM with funct3[2]=1 (CSRRWI/SI/CI) -> fmt ZIMM, imm = zero-extended inst[19:15].
//   Other SYSTEM -> I.
//  IMM_GEN_ZIMM_EN undefined: all SYSTEM -> fmt NONE, imm 0, legal. Encoding 7 is never produced.
// STRUCTURE
//  Shared header imm_gen_defs.vh: opcode localparams, FMT_* codes, width of out_fmt.
//  Sub-module imm_extract (combinational: inst -> imm, fmt, illegal; param XLEN).
//   Instantiated once on the input side; the skid/main registers hold its result.
// TESTING
//  XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0
//  0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=3; XLEN=64 -> 0xFFFFFFFFFFFFFFFC
//  XLEN=64, 0x43F0D093 (srai x1,x1,63) -> out_imm=0x3F, fmt=6; opcode 0x7F -> imm 0, illegal=1
//  Stream of 4 instructions, out_ready=0 for cycles 1-3 -> in_ready=0 after 2 accepts; all 4 delivered in order once out_ready=1
//  FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; rst pulse mid-stream -> outputs 0 immediately
//  0x300FD073 (csrrwi, zimm=31) -> with IMM_GEN_ZIMM_EN imm=0x1F fmt=7; without it imm=0 fmt=0 illegal=0

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared types and encodings for the immediate-generation stage.
// Optional CSR-immediate decode is enabled by IMM_GEN_ZIMM_EN.
package imm_gen_stage_pkg;

  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic is_shift(
    input logic [2:0] f3
  );
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_stage_extract.sv
// Combinational immediate extraction: instruction -> imm, format, illegal.
// SYSTEM CSR-immediate decode is enabled by IMM_GEN_ZIMM_EN.
module imm_extract
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] sh_imm;
  logic [XLEN-1:0] sh32_imm;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];

  assign i_imm = XLEN'($signed(inst[31:20]));
  assign s_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign b_imm = XLEN'($signed({inst[31], inst[7],
                                inst[30:25], inst[11:8],
                                1'b0}));
  assign u_imm = XLEN'($signed({inst[31:12], 12'b0}));
  assign j_imm = XLEN'($signed({inst[31], inst[19:12],
                                inst[20], inst[30:21],
                                1'b0}));

  // Shift amounts are unsigned; RV64 OP-IMM uses a 6-bit field.
  assign sh32_imm = XLEN'(inst[24:20]);
  assign sh_imm   = (XLEN == 64) ? XLEN'(inst[25:20])
                                 : sh32_imm;

`ifdef IMM_GEN_ZIMM_EN
  logic [XLEN-1:0] z_imm;
  assign z_imm = XLEN'(inst[19:15]);
`endif

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        imm = i_imm;
        fmt = FMT_I;
      end
      OPC_OP_IMM: begin
        if (is_shift(f3)) begin
          imm = sh_imm;
          fmt = FMT_SHAMT;
        end else begin
          imm = i_imm;
          fmt = FMT_I;
        end
      end
      OPC_OP_IMM32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift(f3)) begin
          imm = sh32_imm;
          fmt = FMT_SHAMT;
        end else begin
          imm = i_imm;
          fmt = FMT_I;
        end
      end
      OPC_STORE: begin
        imm = s_imm;
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = b_imm;
        fmt = FMT_B;
      end
      OPC_JAL: begin
        imm = j_imm;
        fmt = FMT_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = u_imm;
        fmt = FMT_U;
      end
      OPC_OP, OPC_FENCE: begin
        fmt = FMT_NONE;
      end
      OPC_OP_32: begin
        illegal = (XLEN != 64);
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
        if (f3[2]) begin
          imm = z_imm;
          fmt = FMT_ZIMM;
        end else begin
          imm = i_imm;
          fmt = FMT_I;
        end
`else
        fmt = FMT_NONE;
`endif
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// Optional CSR-immediate decode is enabled by IMM_GEN_ZIMM_EN.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0] x_imm;
  imm_fmt_e        x_fmt;
  logic            x_ill;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst   (in_inst),
    .imm    (x_imm),
    .fmt    (x_fmt),
    .illegal(x_ill)
  );

  stage_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;

  logic [XLEN-1:0]  main_imm_q, main_imm_d;
  imm_fmt_e         main_fmt_q, main_fmt_d;
  logic             main_ill_q, main_ill_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;

  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  imm_fmt_e         skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic accept;
  logic push;

  assign out_valid   = (state_q != ST_EMPTY);
  assign in_ready    = in_ready_q;
  assign accept      = in_valid & in_ready_q;
  assign push        = out_valid & out_ready;

  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    main_ill_d = main_ill_q;
    main_tag_d = main_tag_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    skid_tag_d = skid_tag_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_imm_d = x_imm;
          main_fmt_d = x_fmt;
          main_ill_d = x_ill;
          main_tag_d = in_tag;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && push) begin
          main_imm_d = x_imm;
          main_fmt_d = x_fmt;
          main_ill_d = x_ill;
          main_tag_d = in_tag;
        end else if (accept) begin
          // Main is stalled; park the newcomer behind it.
          skid_imm_d = x_imm;
          skid_fmt_d = x_fmt;
          skid_ill_d = x_ill;
          skid_tag_d = in_tag;
          state_d    = ST_FULL;
        end else if (push) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (push) begin
          main_imm_d = skid_imm_q;
          main_fmt_d = skid_fmt_q;
          main_ill_d = skid_ill_q;
          main_tag_d = skid_tag_q;
          state_d    = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) begin
      state_d    = ST_EMPTY;
      main_imm_d = '0;
      main_fmt_d = FMT_NONE;
      main_ill_d = 1'b0;
      main_tag_d = '0;
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      main_ill_q <= 1'b0;
      main_tag_q <= '0;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
      skid_ill_q <= 1'b0;
      skid_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_imm_q <= main_imm_d;
      main_fmt_q <= main_fmt_d;
      main_ill_q <= main_ill_d;
      main_tag_q <= main_tag_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
      skid_ill_q <= skid_ill_d;
      skid_tag_q <= skid_tag_d;
    end
  end

endmodule
